pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Stall/flush scheduler for the 5-stage integer pipeline. Sits beside the IF/ID, ID/EX,
//   EX/MEM and MEM/WB registers and drives their hold and bubble controls.
//   Detects load-use hazards, holds the front end during multi-cycle EX ops (mul/div),
//   and squashes wrong-path instructions on a taken branch resolved in EX.
// PARAMETERS
//   CNT_W   6   width of multi-cycle length and down-counter (max op length 2^CNT_W-1)
// PORTS
//   clk            in   1      clock, all state updates on rising edge
//   rst_n          in   1      reset, asynchronous, active-low
//   id_rs1_addr    in   5      source reg 1 of instruction in ID
//   id_rs1_re      in   1      ID reads rs1
//   id_rs2_addr    in   5      source reg 2 of instruction in ID
//   id_rs2_re      in   1      ID reads rs2
//   ex_wd          in   5      destination reg of instruction in EX
//   ex_wreg        in   1      EX instruction writes ex_wd
//   ex_is_load     in   1      EX instruction is a load
//   ex_mc_start    in   1      EX holds a multi-cycle op, first cycle (1-cycle pulse)
//   ex_mc_len      in   CNT_W  total EX cycles of that op
//   br_flush       in   1      taken branch/jump resolved in EX this cycle
//   stall          out  5      hold enables: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
//   flush_if_id    out  1      IF/ID loads zero (NOP) at next edge
//   bubble_id_ex   out  1      ID/EX loads zero (NOP) at next edge
//   bubble_ex_mem  out  1      EX/MEM loads zero (NOP) at next edge
//   mc_busy        out  1      FSM in MC state
// BEHAVIOUR
//   - FSM states RUN, MC. Registered: state, mc_cnt[CNT_W-1:0]. Outputs combinational
//     from state, mc_cnt and inputs (zero-latency: stall applies to the coming edge).
//   - Reset: state=RUN, mc_cnt=0; while rst_n=0 all outputs forced 0.
//   - lu_haz = ex_is_load & ex_wreg & ex_wd!=0 & ((id_rs1_re & id_rs1_addr==ex_wd) |
//     (id_rs2_re & id_rs2_addr==ex_wd)). r0 never causes a hazard.
//   - RUN, priority high->low:
//     1 br_flush: stall=0, flush_if_id=1, bubble_id_ex=1; ex_mc_start and lu_haz ignored.
//     2 ex_mc_start & ex_mc_len>=2: stall=5'b00111, bubble_ex_mem=1;
//       next state MC, mc_cnt<=ex_mc_len-2. Len 0 or 1 -> treated as single-cycle op.
//     3 lu_haz: stall=5'b00011, bubble_id_ex=1 (exactly one bubble per hazard).
//     4 else all outputs 0.
//   - MC: stall=5'b00111, bubble_ex_mem=1, mc_busy=1; br_flush, ex_mc_start, lu_haz ignored.
//     mc_cnt!=0 -> mc_cnt<=mc_cnt-1; mc_cnt==0 -> state<=RUN (outputs 0 that cycle,
//     except lu_haz/br_flush evaluated normally on the following RUN cycle).
//   - Op of length N holds EX exactly N cycles: N-1 stalled cycles, EX/MEM captures result
//     on the N-th edge. MEM/WB never stalled (stall[4]=0 always); stall[3]=0 always.
//   - Reset asserted mid-MC: returns to RUN immediately, counter cleared, no stall after.
// CONFIGURATION
//   HAZARD_PERF_CNT_EN defined: adds outputs perf_stall_cyc[31:0] (cycles with stall[0]=1)
//     and perf_flush_cnt[15:0] (cycles with flush_if_id=1); both reset to 0, saturate
//     at all-ones, no wrap.
//   Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   - Load-use: ex_is_load=1,ex_wreg=1,ex_wd=5,id_rs2_re=1,id_rs2_addr=5 -> stall=00011,
//     bubble_id_ex=1 for 1 cycle; same with ex_wd=0 -> all outputs 0.
//   - Multi-cycle: ex_mc_start pulse, ex_mc_len=4 -> stall=00111,bubble_ex_mem=1 for 3 cycles,
//     mc_busy=1 for cycles 2-3, RUN with outputs 0 on 4th cycle; ex_mc_len=1 -> no stall.
//   - Branch: br_flush=1 with lu_haz=1 and ex_mc_start=1,len=8 same cycle -> flush_if_id=1,
//     bubble_id_ex=1, stall=0, state stays RUN.
//   - In MC with mc_cnt=2, br_flush=1 and lu_haz=1 -> ignored, stall=00111 persists to end.
//   - rst_n low during MC (len=20, cycle 5) -> all outputs 0 asynchronously, mc_busy=0
//     after release; with HAZARD_PERF_CNT_EN, perf_stall_cyc=0.
//   - Perf (macro on): len=10 op then two branches -> perf_stall_cyc=9, perf_flush_cnt=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX hazard inputs and the stage hold/bubble controls.
// HAZARD_PERF_CNT_EN adds the performance counter outputs.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 6
);
  logic [4:0]       id_rs1_addr;
  logic             id_rs1_re;
  logic [4:0]       id_rs2_addr;
  logic             id_rs2_re;
  logic [4:0]       ex_wd;
  logic             ex_wreg;
  logic             ex_is_load;
  logic             ex_mc_start;
  logic [CNT_W-1:0] ex_mc_len;
  logic             br_flush;
  logic [4:0]       stall;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             bubble_ex_mem;
  logic             mc_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      perf_stall_cyc;
  logic [15:0]      perf_flush_cnt;
`endif

`ifdef HAZARD_PERF_CNT_EN
  modport master (
    output id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re, ex_wd, ex_wreg,
           ex_is_load, ex_mc_start, ex_mc_len, br_flush,
    input  stall, flush_if_id, bubble_id_ex, bubble_ex_mem, mc_busy,
           perf_stall_cyc, perf_flush_cnt
  );
  modport slave (
    input  id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re, ex_wd, ex_wreg,
           ex_is_load, ex_mc_start, ex_mc_len, br_flush,
    output stall, flush_if_id, bubble_id_ex, bubble_ex_mem, mc_busy,
           perf_stall_cyc, perf_flush_cnt
  );
`else
  modport master (
    output id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re, ex_wd, ex_wreg,
           ex_is_load, ex_mc_start, ex_mc_len, br_flush,
    input  stall, flush_if_id, bubble_id_ex, bubble_ex_mem, mc_busy
  );
  modport slave (
    input  id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re, ex_wd, ex_wreg,
           ex_is_load, ex_mc_start, ex_mc_len, br_flush,
    output stall, flush_if_id, bubble_id_ex, bubble_ex_mem, mc_busy
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, multi-cycle EX holds, branch squash.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall-cycle and flush performance counters).
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, MC = 1'b1} state_e;

  localparam int unsigned STG_W = 5;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_haz_c;
  logic [STG_W-1:0] stall_c;
  logic             flush_c, bub_id_ex_c, bub_ex_mem_c, busy_c;

  // Load in EX feeding a source of the instruction in ID; r0 is never a real dependency.
  always_comb begin
    lu_haz_c = hz.ex_is_load && hz.ex_wreg && (hz.ex_wd != 5'd0) &&
               ((hz.id_rs1_re && (hz.id_rs1_addr == hz.ex_wd)) ||
                (hz.id_rs2_re && (hz.id_rs2_addr == hz.ex_wd)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The MC state's final cycle (cnt==0) releases the hold so EX/MEM captures the result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_c      = '0;
    flush_c      = 1'b0;
    bub_id_ex_c  = 1'b0;
    bub_ex_mem_c = 1'b0;
    busy_c       = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.br_flush) begin
          flush_c     = 1'b1;
          bub_id_ex_c = 1'b1;
        end else if (hz.ex_mc_start && (hz.ex_mc_len >= CNT_W'(2))) begin
          stall_c      = 5'b00111;
          bub_ex_mem_c = 1'b1;
          state_d      = MC;
          cnt_d        = hz.ex_mc_len - CNT_W'(2);
        end else if (lu_haz_c) begin
          stall_c     = 5'b00011;
          bub_id_ex_c = 1'b1;
        end
      end
      MC: begin
        if (cnt_q != '0) begin
          stall_c      = 5'b00111;
          bub_ex_mem_c = 1'b1;
          busy_c       = 1'b1;
          cnt_d        = cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign hz.stall         = rst_n ? stall_c : '0;
  assign hz.flush_if_id   = rst_n & flush_c;
  assign hz.bubble_id_ex  = rst_n & bub_id_ex_c;
  assign hz.bubble_ex_mem = rst_n & bub_ex_mem_c;
  assign hz.mc_busy       = rst_n & busy_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_c[0] && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'(1);
      if (flush_c && (perf_flush_q != '1))    perf_flush_q <= perf_flush_q + 16'(1);
    end
  end

  assign hz.perf_stall_cyc = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned CNT_W = 6;

  localparam logic [8:0] K_ZERO = 9'b00000_0000;
  localparam logic [8:0] K_LU   = 9'b00011_0100;
  localparam logic [8:0] K_MC1  = 9'b00111_0010;
  localparam logic [8:0] K_MCB  = 9'b00111_0011;
  localparam logic [8:0] K_BR   = 9'b00000_1100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  int n_chk  = 0;
  int n_pass = 0;
  // remaining MC-state cycles, the last of which is a non-stalling release cycle
  int mc_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [8:0] model_out();
    logic lu;
    lu = hz.ex_is_load && hz.ex_wreg && (hz.ex_wd != 5'd0) &&
         ((hz.id_rs1_re && hz.id_rs1_addr == hz.ex_wd) ||
          (hz.id_rs2_re && hz.id_rs2_addr == hz.ex_wd));
    if (!rst_n)                                  return K_ZERO;
    if (mc_left > 1)                             return K_MCB;
    if (mc_left == 1)                            return K_ZERO;
    if (hz.br_flush)                             return K_BR;
    if (hz.ex_mc_start && int'(hz.ex_mc_len) >= 2) return K_MC1;
    if (lu)                                      return K_LU;
    return K_ZERO;
  endfunction

  task automatic model_step(input logic [8:0] e);
    if (!rst_n) return;
    if (mc_left > 0) mc_left--;
    else if (!hz.br_flush && hz.ex_mc_start && int'(hz.ex_mc_len) >= 2)
      mc_left = int'(hz.ex_mc_len) - 1;
    if (e[4]) m_stall++;
    if (e[3]) m_flush++;
  endtask

  task automatic cycle(input string tag, input bit use_k = 1'b0, input logic [8:0] k = '0);
    logic [8:0] e, a;
    #1;
    e = model_out();
    a = {hz.stall, hz.flush_if_id, hz.bubble_id_ex, hz.bubble_ex_mem, hz.mc_busy};
    check(tag, 32'(a), 32'(e));
    if (use_k) check({tag, "_k"}, 32'(a), 32'(k));
    model_step(e);
    @(negedge clk);
  endtask

  task automatic idle();
    hz.id_rs1_addr = '0; hz.id_rs1_re = 1'b0;
    hz.id_rs2_addr = '0; hz.id_rs2_re = 1'b0;
    hz.ex_wd = '0; hz.ex_wreg = 1'b0; hz.ex_is_load = 1'b0;
    hz.ex_mc_start = 1'b0; hz.ex_mc_len = '0; hz.br_flush = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] wd);
    hz.ex_is_load = 1'b1; hz.ex_wreg = 1'b1; hz.ex_wd = wd;
    hz.id_rs2_re = 1'b1; hz.id_rs2_addr = wd;
  endtask

  task automatic start_mc(input int len);
    hz.ex_mc_start = 1'b1;
    hz.ex_mc_len = CNT_W'(len);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_outs", 32'({hz.stall, hz.flush_if_id, hz.bubble_id_ex, hz.bubble_ex_mem, hz.mc_busy}), 32'(0));
    mc_left = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_pstall"}, hz.perf_stall_cyc, 32'(m_stall));
    check({tag, "_pflush"}, 32'(hz.perf_flush_cnt), 32'(m_flush));
`else
    if (tag.len() == 0) $display("empty perf tag");
`endif
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    check_perf("rst");

    // load-use hazard, then the same pattern on r0
    set_lu(5'd5);               cycle("lu", 1'b1, K_LU);
    set_lu(5'd0);               cycle("lu_r0", 1'b1, K_ZERO);
    idle(); hz.ex_is_load = 1'b1; hz.ex_wreg = 1'b1; hz.ex_wd = 5'd7;
    hz.id_rs1_re = 1'b1; hz.id_rs1_addr = 5'd7; cycle("lu_rs1", 1'b1, K_LU);
    hz.id_rs1_re = 1'b0;        cycle("lu_nore", 1'b1, K_ZERO);

    // multi-cycle op of length 4, then a length-1 op
    idle(); start_mc(4);        cycle("mc4_c1", 1'b1, K_MC1);
    idle();                     cycle("mc4_c2", 1'b1, K_MCB);
                                cycle("mc4_c3", 1'b1, K_MCB);
                                cycle("mc4_c4", 1'b1, K_ZERO);
    start_mc(1);                cycle("mc1", 1'b1, K_ZERO);
    start_mc(0);                cycle("mc0", 1'b1, K_ZERO);

    // branch overrides a simultaneous hazard and multi-cycle start
    idle(); set_lu(5'd3); start_mc(8); hz.br_flush = 1'b1;
                                cycle("br_pri", 1'b1, K_BR);
    idle();                     cycle("br_after", 1'b1, K_ZERO);

    // branch and hazard ignored while in MC
    start_mc(6);                cycle("mc6_c1", 1'b1, K_MC1);
    idle();                     cycle("mc6_c2", 1'b1, K_MCB);
                                cycle("mc6_c3", 1'b1, K_MCB);
    set_lu(5'd9); hz.br_flush = 1'b1;
                                cycle("mc6_ign", 1'b1, K_MCB);
                                cycle("mc6_c5", 1'b1, K_MCB);
                                cycle("mc6_rel", 1'b1, K_ZERO);
                                cycle("mc6_run", 1'b1, K_BR);

    // asynchronous reset in the middle of a long op
    idle(); start_mc(20);       cycle("mc20_c1");
    idle();
    for (int i = 0; i < 3; i++) cycle("mc20_run");
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'({hz.stall, hz.flush_if_id, hz.bubble_id_ex, hz.bubble_ex_mem, hz.mc_busy}), 32'(0));
    mc_left = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_perf("post_rst");
    cycle("post_rst", 1'b1, K_ZERO);

    // performance scenario: a length-10 op then two branches
    do_reset();
    start_mc(10);               cycle("perf_mc");
    idle();
    for (int i = 0; i < 9; i++) cycle("perf_mcrun");
    hz.br_flush = 1'b1;         cycle("perf_br1");
                                cycle("perf_br2");
    idle();                     cycle("perf_idle");
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall9", hz.perf_stall_cyc, 32'd9);
    check("perf_flush2", 32'(hz.perf_flush_cnt), 32'd2);
`endif

    // randomized traffic biased toward register collisions
    for (int i = 0; i < 2000; i++) begin
      hz.id_rs1_addr = 5'($urandom_range(0, 3));
      hz.id_rs2_addr = 5'($urandom_range(0, 3));
      hz.ex_wd       = 5'($urandom_range(0, 3));
      hz.id_rs1_re   = 1'($urandom_range(0, 1));
      hz.id_rs2_re   = 1'($urandom_range(0, 1));
      hz.ex_wreg     = 1'($urandom_range(0, 3) != 0);
      hz.ex_is_load  = 1'($urandom_range(0, 1));
      hz.ex_mc_start = 1'($urandom_range(0, 7) == 0);
      hz.ex_mc_len   = CNT_W'($urandom_range(0, 12));
      hz.br_flush    = 1'($urandom_range(0, 7) == 0);
      cycle("rand");
      if (i % 250 == 249) check_perf("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
